spu32_cpu_decoder_queue: RTL and testbench

//  Buffered RV32I(+M) decode stage between fetch and execute. Accepts raw instructions with PC over
//  a valid/ready handshake, decodes each into the control bundle used by execute, and checks legality.

---
 rtl/spu32_cpu_decoder_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_spu32_cpu_decoder_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu32_cpu_decoder_queue.sv
// -----------------------------------------------------------------------------
// spu32_cpu_decoder_queue
//
// Buffered RV32I(+M) decode stage that sits between fetch and execute.
// Each incoming instruction word is decoded combinationally into the control
// bundle used by execute, and its legality is checked. The decoded bundle and
// its PC are then written into a DEPTH-entry FIFO. This lets fetch run ahead
// while execute is stalled. A flush (taken branch or trap) empties the queue
// and drops the instruction being offered in the same cycle.
//
// Configuration macro:
//   SPU32_DECODER_MULDIV_EN - when defined, OP with funct7=0000001 and
//     funct3 000..011 decodes to MUL/MULH/MULHSU/MULHU, and funct3 100..111
//     (DIV/REM) is illegal. When undefined, every OP with funct7=0000001 is
//     illegal and no multiply decode logic exists.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Ready never depends combinationally on valid. O_ready
// depends only on reset and occupancy, so it has no path from I_ready. A full
// queue refuses a push even if the head is popped in the same cycle. I_flush
// blocks both transfers in its cycle.
//
// Ports:
//   I_clk, I_reset_n       clock (rising edge), async active-low reset
//   I_flush                drop all queued entries and the current input
//   I_valid/O_ready        input handshake for I_instr/I_pc
//   I_instr, I_pc          raw instruction word and its address
//   O_valid/I_ready        output handshake for the head entry
//   O_pc                   head PC
//   O_rs1/O_rs2/O_rd       register indices (rs1 forced to 0 for LUI)
//   O_imm                  sign-extended immediate (format chosen by opcode)
//   O_opcode, O_funct3     instr[6:2], instr[14:12]
//   O_branchmask           one-hot: bit0 BEQ, bit1 BNE, bit2 BLT, bit3 BGE,
//                          bit4 BLTU, bit5 BGEU; 0 if not a branch
//   O_aluop, O_busop       ALUOP_* / BUSOP_* codes (see localparams)
//   O_alumux1              0 = rs1 value, 1 = PC (JAL, AUIPC)
//   O_alumux2              0 = rs2 value (OP, BRANCH), 1 = immediate
//   O_reginputmux          0 = ALU, 1 = bus, 2 = branch unit, 3 = MSR
//   O_illegal              head entry is an illegal instruction
//   O_count                number of occupied entries
// -----------------------------------------------------------------------------
module spu32_cpu_decoder_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       I_clk,
  input  logic                       I_reset_n,
  input  logic                       I_flush,
  input  logic                       I_valid,
  output logic                       O_ready,
  input  logic [31:0]                I_instr,
  input  logic [31:0]                I_pc,
  output logic                       O_valid,
  input  logic                       I_ready,
  output logic [31:0]                O_pc,
  output logic [4:0]                 O_rs1,
  output logic [4:0]                 O_rs2,
  output logic [4:0]                 O_rd,
  output logic [31:0]                O_imm,
  output logic [4:0]                 O_opcode,
  output logic [2:0]                 O_funct3,
  output logic [5:0]                 O_branchmask,
  output logic [3:0]                 O_aluop,
  output logic [2:0]                 O_busop,
  output logic                       O_alumux1,
  output logic                       O_alumux2,
  output logic [1:0]                 O_reginputmux,
  output logic                       O_illegal,
  output logic [$clog2(DEPTH+1)-1:0] O_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Opcodes (instr[6:2])
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // ALU operation codes
  localparam logic [3:0] ALUOP_ADD    = 4'd0;
  localparam logic [3:0] ALUOP_SUB    = 4'd1;
  localparam logic [3:0] ALUOP_AND    = 4'd2;
  localparam logic [3:0] ALUOP_OR     = 4'd3;
  localparam logic [3:0] ALUOP_XOR    = 4'd4;
  localparam logic [3:0] ALUOP_SLT    = 4'd5;
  localparam logic [3:0] ALUOP_SLTU   = 4'd6;
  localparam logic [3:0] ALUOP_SLL    = 4'd7;
  localparam logic [3:0] ALUOP_SRL    = 4'd8;
  localparam logic [3:0] ALUOP_SRA    = 4'd9;
`ifdef SPU32_DECODER_MULDIV_EN
  localparam logic [3:0] ALUOP_MUL    = 4'd10;
  localparam logic [3:0] ALUOP_MULH   = 4'd11;
  localparam logic [3:0] ALUOP_MULHSU = 4'd12;
  localparam logic [3:0] ALUOP_MULHU  = 4'd13;
`endif

  // Bus operation codes. Non-memory instructions carry code 0.
  localparam logic [2:0] BUSOP_READB  = 3'd0;
  localparam logic [2:0] BUSOP_READH  = 3'd1;
  localparam logic [2:0] BUSOP_READW  = 3'd2;
  localparam logic [2:0] BUSOP_WRITEW = 3'd3;
  localparam logic [2:0] BUSOP_READBU = 3'd4;
  localparam logic [2:0] BUSOP_READHU = 3'd5;
  localparam logic [2:0] BUSOP_WRITEB = 3'd6;
  localparam logic [2:0] BUSOP_WRITEH = 3'd7;

  // Register-input mux selections
  localparam logic [1:0] RIM_ALU    = 2'd0;
  localparam logic [1:0] RIM_BUS    = 2'd1;
  localparam logic [1:0] RIM_BRANCH = 2'd2;
  localparam logic [1:0] RIM_MSR    = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [5:0]  branchmask;
    logic [3:0]  aluop;
    logic [2:0]  busop;
    logic        alumux1;
    logic        alumux2;
    logic [1:0]  reginputmux;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------------
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [3:0]  base_aluop;
  entry_t      dec;

  assign opcode = I_instr[6:2];
  assign funct3 = I_instr[14:12];
  assign funct7 = I_instr[31:25];

  assign imm_i = {{20{I_instr[31]}}, I_instr[31:20]};
  assign imm_s = {{20{I_instr[31]}}, I_instr[31:25], I_instr[11:7]};
  assign imm_b = {{20{I_instr[31]}}, I_instr[7], I_instr[30:25], I_instr[11:8], 1'b0};
  assign imm_u = {I_instr[31:12], 12'h000};
  assign imm_j = {{12{I_instr[31]}}, I_instr[19:12], I_instr[20], I_instr[30:21], 1'b0};

  // ALU op shared by OP and OP-IMM. SUB only exists for register-register
  // operations: for OP-IMM, funct7 bit 5 of ADDI is immediate data.
  always_comb begin
    base_aluop = ALUOP_ADD;
    unique case (funct3)
      3'b000: base_aluop = (opcode == OPC_OP && funct7[5]) ? ALUOP_SUB : ALUOP_ADD;
      3'b001: base_aluop = ALUOP_SLL;
      3'b010: base_aluop = ALUOP_SLT;
      3'b011: base_aluop = ALUOP_SLTU;
      3'b100: base_aluop = ALUOP_XOR;
      3'b101: base_aluop = funct7[5] ? ALUOP_SRA : ALUOP_SRL;
      3'b110: base_aluop = ALUOP_OR;
      3'b111: base_aluop = ALUOP_AND;
      default: base_aluop = ALUOP_ADD;
    endcase
  end

  always_comb begin
    dec             = '0;
    dec.pc          = I_pc;
    dec.rs1         = (opcode == OPC_LUI) ? 5'd0 : I_instr[19:15];
    dec.rs2         = I_instr[24:20];
    dec.rd          = I_instr[11:7];
    dec.opcode      = opcode;
    dec.funct3      = funct3;
    dec.imm         = imm_i;
    dec.aluop       = ALUOP_ADD;
    dec.busop       = BUSOP_READB;
    dec.alumux1     = 1'b0;
    dec.alumux2     = 1'b1;
    dec.reginputmux = RIM_ALU;
    dec.branchmask  = 6'b000000;
    // Anything not in the 32-bit encoding space is illegal regardless of opcode.
    dec.illegal     = (I_instr[1:0] != 2'b11);

    unique case (opcode)
      OPC_LOAD: begin
        dec.reginputmux = RIM_BUS;
        unique case (funct3)
          3'b000: dec.busop = BUSOP_READB;
          3'b001: dec.busop = BUSOP_READH;
          3'b010: dec.busop = BUSOP_READW;
          3'b100: dec.busop = BUSOP_READBU;
          3'b101: dec.busop = BUSOP_READHU;
          default: dec.illegal = 1'b1;
        endcase
      end

      OPC_STORE: begin
        dec.imm = imm_s;
        unique case (funct3)
          3'b000: dec.busop = BUSOP_WRITEB;
          3'b001: dec.busop = BUSOP_WRITEH;
          3'b010: dec.busop = BUSOP_WRITEW;
          default: dec.illegal = 1'b1;
        endcase
      end

      OPC_BRANCH: begin
        dec.imm     = imm_b;
        dec.alumux2 = 1'b0;
        unique case (funct3)
          3'b000: dec.branchmask = 6'b000001;
          3'b001: dec.branchmask = 6'b000010;
          3'b100: dec.branchmask = 6'b000100;
          3'b101: dec.branchmask = 6'b001000;
          3'b110: dec.branchmask = 6'b010000;
          3'b111: dec.branchmask = 6'b100000;
          default: dec.illegal = 1'b1;
        endcase
      end

      OPC_JAL: begin
        dec.imm         = imm_j;
        dec.alumux1     = 1'b1;
        dec.reginputmux = RIM_BRANCH;
      end

      OPC_JALR: begin
        dec.reginputmux = RIM_BRANCH;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end

      OPC_OP: begin
        dec.alumux2 = 1'b0;
        dec.aluop   = base_aluop;
        if (funct7 == 7'b0000000) begin
          // plain base-ISA operation
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          // SUB / SRA
`ifdef SPU32_DECODER_MULDIV_EN
        end else if (funct7 == 7'b0000001 && !funct3[2]) begin
          unique case (funct3[1:0])
            2'b00: dec.aluop = ALUOP_MUL;
            2'b01: dec.aluop = ALUOP_MULH;
            2'b10: dec.aluop = ALUOP_MULHSU;
            2'b11: dec.aluop = ALUOP_MULHU;
            default: dec.aluop = ALUOP_MUL;
          endcase
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end

      OPC_OPIMM: begin
        dec.aluop = base_aluop;
        // Only the shift immediates reserve funct7; other OP-IMM forms use
        // those bits as immediate data.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) dec.illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          dec.illegal = 1'b1;
      end

      OPC_LUI: begin
        dec.imm = imm_u;
      end

      OPC_AUIPC: begin
        dec.imm     = imm_u;
        dec.alumux1 = 1'b1;
      end

      OPC_SYSTEM: begin
        dec.reginputmux = RIM_MSR;
      end

      OPC_MISC_MEM: begin
        // FENCE: no datapath effect beyond the default bundle
      end

      default: dec.illegal = 1'b1;
    endcase

    // An illegal entry must not steer a branch, an odd ALU op or a
    // write-back source; execute only needs to see O_illegal and trap.
    if (dec.illegal) begin
      dec.branchmask  = 6'b000000;
      dec.aluop       = ALUOP_ADD;
      dec.reginputmux = RIM_ALU;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic          push;
  logic          pop;

  assign O_ready = I_reset_n & (count < DEPTH_C);
  assign O_valid = (count != '0);
  assign push    = I_valid & O_ready & ~I_flush;
  assign pop     = O_valid & I_ready & ~I_flush;

  // Pointers are PW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH by natural overflow.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (I_flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset: nothing reaches the outputs unless the
  // slot is counted as occupied.
  always_ff @(posedge I_clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head = O_valid ? mem[rd_ptr] : '0;

  assign O_pc          = head.pc;
  assign O_rs1         = head.rs1;
  assign O_rs2         = head.rs2;
  assign O_rd          = head.rd;
  assign O_imm         = head.imm;
  assign O_opcode      = head.opcode;
  assign O_funct3      = head.funct3;
  assign O_branchmask  = head.branchmask;
  assign O_aluop       = head.aluop;
  assign O_busop       = head.busop;
  assign O_alumux1     = head.alumux1;
  assign O_alumux2     = head.alumux2;
  assign O_reginputmux = head.reginputmux;
  assign O_illegal     = head.illegal;
  assign O_count       = count;

endmodule

// File: tb/tb_spu32_cpu_decoder_queue.sv
// -----------------------------------------------------------------------------
// tb_spu32_cpu_decoder_queue
//
// Bench for the buffered decode queue. It holds a queue of expected decoded
// entries. Each entry is built from the instruction-set rules by a reference
// decode function. The queue is advanced on every clock edge from the
// handshake inputs. Every falling edge compares the whole output bundle
// against the queue head. Directed tests add literal expectations for
// reset, latency, full/empty, push+pop, flush and M-extension behaviour.
// -----------------------------------------------------------------------------
module tb_spu32_cpu_decoder_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SPU32_DECODER_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  // opcodes
  localparam logic [4:0] LOAD = 5'b00000, MISC_MEM = 5'b00011, OPIMM = 5'b00100;
  localparam logic [4:0] AUIPC = 5'b00101, STORE = 5'b01000, OP = 5'b01100;
  localparam logic [4:0] LUI = 5'b01101, BRANCH = 5'b11000, JALR = 5'b11001;
  localparam logic [4:0] JAL = 5'b11011, SYSTEM = 5'b11100;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [5:0]  branchmask;
    logic [3:0]  aluop;
    logic [2:0]  busop;
    logic        alumux1;
    logic        alumux2;
    logic [1:0]  reginputmux;
    logic        illegal;
  } exp_t;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          I_flush, I_valid, I_ready;
  logic [31:0]   I_instr, I_pc;
  logic          O_ready, O_valid;
  logic [31:0]   O_pc, O_imm;
  logic [4:0]    O_rs1, O_rs2, O_rd, O_opcode;
  logic [2:0]    O_funct3, O_busop;
  logic [5:0]    O_branchmask;
  logic [3:0]    O_aluop;
  logic          O_alumux1, O_alumux2, O_illegal;
  logic [1:0]    O_reginputmux;
  logic [CW-1:0] O_count;

  spu32_cpu_decoder_queue #(.DEPTH(DEPTH)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_flush(I_flush), .I_valid(I_valid),
    .O_ready(O_ready), .I_instr(I_instr), .I_pc(I_pc), .O_valid(O_valid),
    .I_ready(I_ready), .O_pc(O_pc), .O_rs1(O_rs1), .O_rs2(O_rs2), .O_rd(O_rd),
    .O_imm(O_imm), .O_opcode(O_opcode), .O_funct3(O_funct3),
    .O_branchmask(O_branchmask), .O_aluop(O_aluop), .O_busop(O_busop),
    .O_alumux1(O_alumux1), .O_alumux2(O_alumux2),
    .O_reginputmux(O_reginputmux), .O_illegal(O_illegal), .O_count(O_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode from the instruction-set rules.
  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          sv;
    bit          bad;
    op = w[6:2];
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.pc     = pc;
    e.rd     = w[11:7];
    e.rs2    = w[24:20];
    e.rs1    = (op == LUI) ? 5'd0 : w[19:15];
    e.opcode = op;
    e.funct3 = f3;

    case (op)
      STORE:      sv = $signed({w[31:25], w[11:7]});
      BRANCH:     sv = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      JAL:        sv = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      LUI, AUIPC: sv = {w[31:12], 12'h000};
      default:    sv = $signed(w[31:20]);
    endcase
    e.imm = sv;

    e.alumux1 = (op == JAL || op == AUIPC);
    e.alumux2 = !(op == OP || op == BRANCH);
    case (op)
      LOAD:      e.reginputmux = 2'd1;
      JAL, JALR: e.reginputmux = 2'd2;
      SYSTEM:    e.reginputmux = 2'd3;
      default:   e.reginputmux = 2'd0;
    endcase

    // bus codes: READB0 READH1 READW2 WRITEW3 READBU4 READHU5 WRITEB6 WRITEH7
    if (op == LOAD && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) e.busop = f3;
    if (op == STORE && f3 == 3'd0) e.busop = 3'd6;
    if (op == STORE && f3 == 3'd1) e.busop = 3'd7;
    if (op == STORE && f3 == 3'd2) e.busop = 3'd3;

    // branch condition index: BEQ,BNE at f3 0,1; BLT..BGEU at f3 4..7
    if (op == BRANCH && !(f3 inside {3'd2, 3'd3}))
      e.branchmask = 6'(1 << ((f3 < 3'd2) ? f3 : f3 - 3'd2));

    // alu codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9 MUL10..MULHU13
    if (op == OP || op == OPIMM) begin
      case (f3)
        3'd0: e.aluop = (op == OP && f7[5]) ? 4'd1 : 4'd0;
        3'd1: e.aluop = 4'd7;
        3'd2: e.aluop = 4'd5;
        3'd3: e.aluop = 4'd6;
        3'd4: e.aluop = 4'd4;
        3'd5: e.aluop = f7[5] ? 4'd9 : 4'd8;
        3'd6: e.aluop = 4'd3;
        default: e.aluop = 4'd2;
      endcase
      if (op == OP && MULDIV && f7 == 7'd1 && f3 < 3'd4) e.aluop = 4'd10 + 4'(f3);
    end

    bad = (w[1:0] != 2'b11);
    case (op)
      LOAD:   if (f3 inside {3'd3, 3'd6, 3'd7}) bad = 1'b1;
      STORE:  if (f3 >= 3'd3) bad = 1'b1;
      BRANCH: if (f3 inside {3'd2, 3'd3}) bad = 1'b1;
      JALR:   if (f3 != 3'd0) bad = 1'b1;
      OP: if (!((f7 == 7'd0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
                (MULDIV && f7 == 7'd1 && f3 < 3'd4))) bad = 1'b1;
      OPIMM: begin
        if (f3 == 3'd1 && f7 != 7'd0) bad = 1'b1;
        if (f3 == 3'd5 && !(f7 inside {7'd0, 7'h20})) bad = 1'b1;
      end
      JAL, LUI, AUIPC, SYSTEM, MISC_MEM: ;
      default: bad = 1'b1;
    endcase
    e.illegal = bad;
    if (bad) begin
      e.branchmask  = '0;
      e.aluop       = 4'd0;
      e.reginputmux = 2'd0;
    end
    return e;
  endfunction

  // Model state advance on each edge from the sampled handshake inputs.
  always @(posedge clk or negedge rst_n) begin
    int n;
    n = exp_q.size();
    if (!rst_n || I_flush) begin
      exp_q.delete();
    end else begin
      if (n != 0 && I_ready) void'(exp_q.pop_front());
      if (I_valid && n < DEPTH) exp_q.push_back(model_decode(I_instr, I_pc));
    end
  end

  // Compare process: full bundle against the model, every cycle.
  always @(negedge clk) begin
    exp_t e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("count",       32'(O_count), 32'(exp_q.size()));
    check("ready",       32'(O_ready), 32'(rst_n && exp_q.size() < DEPTH));
    check("valid",       32'(O_valid), 32'(exp_q.size() != 0));
    check("pc",          O_pc, e.pc);
    check("rs1",         32'(O_rs1), 32'(e.rs1));
    check("rs2",         32'(O_rs2), 32'(e.rs2));
    check("rd",          32'(O_rd), 32'(e.rd));
    check("imm",         O_imm, e.imm);
    check("opcode",      32'(O_opcode), 32'(e.opcode));
    check("funct3",      32'(O_funct3), 32'(e.funct3));
    check("branchmask",  32'(O_branchmask), 32'(e.branchmask));
    check("aluop",       32'(O_aluop), 32'(e.aluop));
    check("busop",       32'(O_busop), 32'(e.busop));
    check("alumux1",     32'(O_alumux1), 32'(e.alumux1));
    check("alumux2",     32'(O_alumux2), 32'(e.alumux2));
    check("reginputmux", 32'(O_reginputmux), 32'(e.reginputmux));
    check("illegal",     32'(O_illegal), 32'(e.illegal));
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    I_valid = v;
    I_instr = ins;
    I_pc    = pc;
    I_ready = rdy;
    I_flush = fl;
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 21;
  logic [31:0] vec [NV] = '{
    32'h40208033, 32'h4020D0B3, 32'h4020C0B3, 32'h4030D093, 32'h40309093,
    32'h123450B7, 32'h00001097, 32'h008000EF, 32'h000080E7, 32'h000090E7,
    32'h00209023, 32'h0020B023, 32'h0000B083, 32'h00002463, 32'h00000073,
    32'h0000000F, 32'h00000013, 32'h00000000, 32'h0000007F, 32'h0220C1B3,
    32'hFE20CEE3
  };

  initial begin
    int i;
    int budget;
    bit acc;
    I_flush = 1'b0; I_valid = 1'b0; I_ready = 1'b0; I_instr = '0; I_pc = '0;

    // 1. reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(O_valid), 32'd0);
    check("rst_ready", 32'(O_ready), 32'd0);
    check("rst_count", 32'(O_count), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rel_ready", 32'(O_ready), 32'd1);

    // 2. ADDI x1,x0,5 at 0x100, one-edge latency
    drive(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    check("addi_valid", 32'(O_valid), 32'd1);
    check("addi_rd", 32'(O_rd), 32'd1);
    check("addi_rs1", 32'(O_rs1), 32'd0);
    check("addi_imm", O_imm, 32'd5);
    check("addi_aluop", 32'(O_aluop), 32'd0);
    check("addi_alumux2", 32'(O_alumux2), 32'd1);
    check("addi_pc", O_pc, 32'h100);
    check("addi_illegal", 32'(O_illegal), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("addi_popped", 32'(O_count), 32'd0);

    // 3. fill, extra push refused, drain in order
    for (int k = 0; k < DEPTH; k++)
      drive(1'b1, 32'h00000093 | (32'(k + 1) << 20), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
    check("full_count", 32'(O_count), DEPTH);
    check("full_ready", 32'(O_ready), 32'd0);
    drive(1'b1, 32'h00000013, 32'h2F0, 1'b0, 1'b0);
    check("full_extra_count", 32'(O_count), DEPTH);
    check("full_head_pc", O_pc, 32'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pop1_count", 32'(O_count), DEPTH - 1);
    check("pop1_ready", 32'(O_ready), 32'd1);
    check("pop1_pc", O_pc, 32'h204);
    check("pop1_imm", O_imm, 32'd2);
    for (int k = 1; k < DEPTH; k++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained", 32'(O_count), 32'd0);

    // 4. push + pop at count=1
    drive(1'b1, 32'h00700113, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h00900193, 32'h304, 1'b1, 1'b0);
    check("pp_count", 32'(O_count), 32'd1);
    check("pp_pc", O_pc, 32'h304);
    check("pp_rd", 32'(O_rd), 32'd3);

    // 5. flush at count=2 with a valid input
    drive(1'b1, 32'h00B00213, 32'h308, 1'b0, 1'b0);
    check("pre_flush_count", 32'(O_count), 32'd2);
    drive(1'b1, 32'h00D00293, 32'h30C, 1'b0, 1'b1);
    check("flush_count", 32'(O_count), 32'd0);
    check("flush_valid", 32'(O_valid), 32'd0);
    check("flush_pc", O_pc, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_dropped", 32'(O_count), 32'd0);

    // 6. MUL and all-ones
    drive(1'b1, 32'h022081B3, 32'h400, 1'b0, 1'b0);
    if (MULDIV) check("mul_aluop", 32'(O_aluop), 32'd10);
    else        check("mul_aluop", 32'(O_aluop), 32'd0);
    check("mul_illegal", 32'(O_illegal), 32'(!MULDIV));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 32'h404, 1'b0, 1'b0);
    check("ones_illegal", 32'(O_illegal), 32'd1);
    check("ones_branchmask", 32'(O_branchmask), 32'd0);
    check("ones_reginputmux", 32'(O_reginputmux), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // BEQ x1,x2,+8 and LW x2,4(x1)
    drive(1'b1, 32'h00208463, 32'h408, 1'b0, 1'b0);
    check("beq_mask", 32'(O_branchmask), 32'd1);
    check("beq_imm", O_imm, 32'd8);
    check("beq_alumux2", 32'(O_alumux2), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0040A103, 32'h40C, 1'b0, 1'b0);
    check("lw_busop", 32'(O_busop), 32'd2);
    check("lw_reginputmux", 32'(O_reginputmux), 32'd1);
    check("lw_imm", O_imm, 32'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stream of mixed legal/illegal encodings with random execute stalls
    i = 0;
    budget = 0;
    while (i < NV && budget < 400) begin
      I_valid = 1'b1;
      I_instr = vec[i];
      I_pc    = 32'h1000 + 32'(4 * i);
      I_ready = 1'($urandom_range(0, 1));
      I_flush = 1'b0;
      acc = O_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      budget++;
    end
    check("stream_done", 32'(i), 32'(NV));
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      budget++;
    end
    check("stream_drain", 32'(O_count), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
